// File: rtl/demux_pkg.sv
// Shared defaults and drop-counter constants for the stream demultiplexer.
package demux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_N     = 4;

  localparam int unsigned           DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel: a single data/valid register with load and drain.
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             can_accept
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A load on the same edge as a drain wins, so the channel never bubbles.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && drain_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign can_accept = !valid_q || drain_ready;

endmodule

// File: rtl/demux_stream.sv
// Stream demultiplexer: routes one input word to a selected channel or to all channels.
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned SW    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      d,
  input  logic [SW-1:0]         s,
  input  logic                  bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N*WIDTH-1:0]    y,
  output logic [N-1:0]          y_valid,
  input  logic [N-1:0]          y_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned SelSpan = 1 << SW;

  logic [N-1:0]          can_accept;
  logic [SelSpan-1:0]    can_accept_ext;
  logic [N-1:0]          load;
  logic                  sel_ok;
  logic                  accept;
  logic                  drop_inc;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign sel_ok = (32'(s) < N);

  // Unused select codes read as ready so the index never leaves the vector.
  always_comb begin
    can_accept_ext        = '1;
    can_accept_ext[N-1:0] = can_accept;
    if (!rst_n) begin
      in_ready = 1'b0;
    end else if (bcast) begin
      in_ready = &can_accept;
    end else if (!sel_ok) begin
      in_ready = 1'b1;
    end else begin
      in_ready = can_accept_ext[s];
    end
  end

  assign accept   = in_valid && in_ready;
  assign drop_inc = accept && !bcast && !sel_ok;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < N; k++) begin
      load[k] = accept && (bcast || (sel_ok && (32'(s) == k)));
    end
  end

  for (genvar k = 0; k < N; k++) begin : gen_chan
    demux_chan_reg #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load[k]),
      .load_data  (d),
      .drain_ready(y_ready[k]),
      .data       (y[k*WIDTH +: WIDTH]),
      .valid      (y_valid[k]),
      .can_accept (can_accept[k])
    );
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: a 4-channel and a 5-channel instance share clock and reset.
module tb_demux_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  d;
  logic        bcast;

  logic [1:0]  s4;
  logic        in_valid4, in_ready4;
  logic [31:0] y4;
  logic [3:0]  y_valid4, y_ready4;
  logic [7:0]  drop4;

  logic [2:0]  s5;
  logic        in_valid5, in_ready5;
  logic [39:0] y5;
  logic [4:0]  y_valid5, y_ready5;
  logic [7:0]  drop5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_stream #(.WIDTH(8), .N(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .s       (s4),
    .bcast   (bcast),
    .in_valid(in_valid4),
    .in_ready(in_ready4),
    .y       (y4),
    .y_valid (y_valid4),
    .y_ready (y_ready4),
    .drop_cnt(drop4)
  );

  demux_stream #(.WIDTH(8), .N(5)) dut5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .s       (s5),
    .bcast   (1'b0),
    .in_valid(in_valid5),
    .in_ready(in_ready5),
    .y       (y5),
    .y_valid (y_valid5),
    .y_ready (y_ready5),
    .drop_cnt(drop5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; d = '0; bcast = 1'b0;
    s4 = '0; in_valid4 = 1'b0; y_ready4 = '0;
    s5 = '0; in_valid5 = 1'b0; y_ready5 = '0;
    tick;
    tick;
    chk("rst_in_ready4", in_ready4, 1'b0);
    chk("rst_y_valid4", y_valid4, 4'h0);
    chk("rst_y4", y4, 32'h0);
    chk("rst_drop5", drop5, 8'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready4", in_ready4, 1'b1);

    // Walk one word across every channel
    y_ready4 = 4'hF; d = 8'hA5; in_valid4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s4 = 2'(i);
      tick;
      chk("onehot_valid", y_valid4, 64'(1) << i);
      chk("onehot_data", y4[i*8 +: 8], 8'hA5);
    end
    in_valid4 = 1'b0;
    tick;
    chk("drain_valid", y_valid4, 4'h0);
    chk("drain_retains", y4, 32'hA5A5A5A5);

    // Backpressure on channel 2
    y_ready4 = 4'b1011; s4 = 2'd2; d = 8'h11; in_valid4 = 1'b1;
    #1 chk("ch2_first_ready", in_ready4, 1'b1);
    tick;
    chk("ch2_first_valid", y_valid4, 4'b0100);
    chk("ch2_first_data", y4[23:16], 8'h11);
    d = 8'h22;
    #1 chk("ch2_stall_ready", in_ready4, 1'b0);
    tick;
    chk("ch2_stall_valid", y_valid4, 4'b0100);
    chk("ch2_stall_data", y4[23:16], 8'h11);
    y_ready4 = 4'hF;
    #1 chk("ch2_release_ready", in_ready4, 1'b1);
    tick;
    chk("ch2_second_valid", y_valid4, 4'b0100);
    chk("ch2_second_data", y4[23:16], 8'h22);
    in_valid4 = 1'b0;
    tick;
    chk("ch2_drained", y_valid4, 4'h0);

    // Broadcast
    y_ready4 = 4'h0; bcast = 1'b1; d = 8'h33; in_valid4 = 1'b1;
    #1 chk("bc_empty_ready", in_ready4, 1'b1);
    tick;
    chk("bc_fill_valid", y_valid4, 4'hF);
    chk("bc_fill_data", y4, 32'h33333333);
    d = 8'h44; y_ready4 = 4'b1011;
    #1 chk("bc_blocked_ready", in_ready4, 1'b0);
    tick;
    chk("bc_blocked_valid", y_valid4, 4'b0100);
    chk("bc_blocked_data", y4, 32'h33333333);
    y_ready4[2] = 1'b1;
    #1 chk("bc_release_ready", in_ready4, 1'b1);
    tick;
    chk("bc_load_valid", y_valid4, 4'hF);
    chk("bc_load_data", y4, 32'h44444444);
    in_valid4 = 1'b0; bcast = 1'b0;
    tick;
    chk("bc_drained", y_valid4, 4'h0);

    // Zero-bubble reload of channel 1
    s4 = 2'd1; d = 8'h55; in_valid4 = 1'b1;
    tick;
    chk("zb_first_valid", y_valid4, 4'b0010);
    chk("zb_first_data", y4[15:8], 8'h55);
    d = 8'h66;
    #1 chk("zb_ready", in_ready4, 1'b1);
    tick;
    chk("zb_second_valid", y_valid4, 4'b0010);
    chk("zb_second_y", y4, 32'h44446644);
    in_valid4 = 1'b0; y_ready4 = 4'h0;
    tick;
    chk("zb_hold_valid", y_valid4, 4'b0010);
    chk("zb_hold_data", y4[15:8], 8'h66);

    // Out-of-range select on N=5 saturates the drop counter
    s5 = 3'd6; in_valid5 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick;
      chk("sat_drop", drop5, (i + 1 > 255) ? 255 : i + 1);
      chk("sat_no_valid", y_valid5, 5'h0);
      chk("sat_ready", in_ready5, 1'b1);
    end
    in_valid5 = 1'b0;
    rst_n = 1'b0;
    tick;
    chk("sat_reset_drop", drop5, 8'd0);
    rst_n = 1'b1;

    // Build state with data and drop_cnt=7, then reset
    in_valid5 = 1'b1; s5 = 3'd6;
    repeat (7) tick;
    chk("drop_seven", drop5, 8'd7);
    s5 = 3'd0; d = 8'h77;
    tick;
    s5 = 3'd4; d = 8'h88;
    tick;
    in_valid5 = 1'b0;
    tick;
    chk("pre_rst_valid5", y_valid5, 5'b10001);
    chk("pre_rst_y5", y5, 40'h88_0000_0077);
    rst_n = 1'b0; in_valid4 = 1'b1; s4 = 2'd0; in_valid5 = 1'b1; s5 = 3'd1; d = 8'h99;
    #1;
    chk("in_rst_ready4", in_ready4, 1'b0);
    chk("in_rst_ready5", in_ready5, 1'b0);
    tick;
    chk("rst_valid4", y_valid4, 4'h0);
    chk("rst_data4", y4, 32'h0);
    chk("rst_valid5", y_valid5, 5'h0);
    chk("rst_data5", y5, 40'h0);
    chk("rst_drop5b", drop5, 8'd0);
    rst_n = 1'b1;
    #1 chk("release_ready5", in_ready5, 1'b1);
    tick;
    chk("first_accept_valid5", y_valid5, 5'b00010);
    chk("first_accept_data5", y5[15:8], 8'h99);
    in_valid4 = 1'b0; in_valid5 = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter N, default 4, number of output channels (2..16, need not be a power of 2).
REQ-003 Parameter SW, default $clog2(N), select width; SHALL NOT be overridden independently of N.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 d  input  WIDTH  input data word.
REQ-007 s  input  SW  channel select.
REQ-008 bcast  input  1  broadcast mode: word goes to every channel.
REQ-009 in_valid  input  1  d/s/bcast qualified.
REQ-010 in_ready  output  1  block can accept this cycle.
REQ-011 y  output  N*WIDTH  flattened channel data; channel k at bits [k*WIDTH +: WIDTH].
REQ-012 y_valid  output  N  per-channel data valid.
REQ-013 y_ready  input  N  per-channel consumer ready.
REQ-014 drop_cnt  output  8  count of words accepted with out-of-range select.

Function
REQ-015 Each channel SHALL hold a one-entry output register (data + valid); one-cycle latency from accept to y_valid.
REQ-016 Transfer in: in_valid && in_ready at rising edge; transfer out on channel k: y_valid[k] && y_ready[k].
REQ-017 Channel k "can accept" = !y_valid[k] || y_ready[k] (combinational pass-through of y_ready).
REQ-018 bcast=0, s<N: in_ready = can-accept of channel s.
REQ-019 bcast=1: in_ready = AND of can-accept over all N channels; s ignored.
REQ-020 bcast=0, s>=N: in_ready=1; word discarded, no channel changes, drop_cnt increments by 1.
REQ-021 drop_cnt SHALL saturate at 255.
REQ-022 On accept, target channel(s) load d and set y_valid at next edge.
REQ-023 Simultaneous drain and load on the same channel: load wins, y_valid stays 1, data updated — zero-bubble throughput.
REQ-024 Drain without load: y_valid[k] clears at next edge; y data register retains last value.
REQ-025 Non-targeted channels SHALL be unaffected by any accept.
REQ-026 in_ready SHALL NOT depend on in_valid; y_valid SHALL NOT depend on y_ready in the same cycle.
REQ-027 When y_valid[k]=1 and y_ready[k]=0, channel k data and valid SHALL hold stable.

Reset
REQ-028 rst_n=0 at a rising edge: all y_valid=0, all y data=0, drop_cnt=0; any word in flight is lost.
REQ-029 During reset in_ready SHALL be 0; first accept possible on the first edge with rst_n=1.

Structure
REQ-030 Shared package demux_pkg SHALL hold default WIDTH/N, drop counter width (8) and its saturation value.
REQ-031 One sub-module demux_chan_reg (single channel data/valid register with load/drain) SHALL be instantiated N times via generate.

Verification
REQ-032 N=4, WIDTH=8, bcast=0, all y_ready=1: d=A5 with s=0,1,2,3 on consecutive cycles -> y_valid one-hot 0001,0010,0100,1000 one cycle later, data A5 on that channel.
REQ-033 y_ready[2]=0: send 11 then 22 to s=2 -> 11 held on channel 2, in_ready=0 for the second word until y_ready[2]=1; 22 appears the cycle after.
REQ-034 bcast=1, y_ready=4'b1011, all channels full -> in_ready=0; raise y_ready[2] -> accept, all four channels show the word next cycle.
REQ-035 N=5 (SW=3), s=6, in_valid for 300 cycles -> in_ready=1 throughout, no y_valid change, drop_cnt saturates at 255.
REQ-036 Channel 1 full with y_ready[1]=1, new word to s=1 in same cycle -> y_valid[1] stays 1, data replaced, no bubble.
REQ-037 rst_n=0 while channels hold data and drop_cnt=7 -> next edge all y_valid=0, y=0, drop_cnt=0, in_ready=0 during reset.
